// File: rtl/md4_compress.sv
// md4_compress: iterative MD4 compression engine.
// Accepts a padded 512-bit block plus a 128-bit chaining state on a rising
// edge of irdy and runs the 48 MD4 steps at UNROLL steps per clock. It then
// presents state + round result on newstate_* with ordy held high.
module md4_compress #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         irdy,
   input  logic [31:0]  state_a,
   input  logic [31:0]  state_b,
   input  logic [31:0]  state_c,
   input  logic [31:0]  state_d,
   input  logic [511:0] data,
   output logic         ordy,
   output logic [31:0]  newstate_a,
   output logic [31:0]  newstate_b,
   output logic [31:0]  newstate_c,
   output logic [31:0]  newstate_d
);

   // Only divisors of 4 keep the a/b/c/d rotation aligned at every clock.
   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("md4_compress: UNROLL must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [5:0] STEPS_DONE = 6'd48;

   state_t      state_q, state_d_nx;
   logic        irdy_q;
   logic        start;
   logic        load;
   logic        finish;
   logic [5:0]  step_q;
   logic [31:0] a_q, b_q, c_q, d_q;
   logic [31:0] ia_q, ib_q, ic_q, id_q;
   logic [31:0] x_q [16];
   logic [31:0] a_nx, b_nx, c_nx, d_nx;

   // scratch for the combinational step chain
   logic [31:0] wa, wb, wc, wd, f, kc, t;
   logic [5:0]  s;
   logic [3:0]  j;
   logic [3:0]  k;
   logic [4:0]  sh;

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] n);
      logic [63:0] w;
      w = {v, v} << n;
      return w[63:32];
   endfunction

   assign start  = irdy & ~irdy_q;
   assign load   = start && (state_q != S_RUN);
   assign finish = (state_q == S_RUN) && (step_q == STEPS_DONE);

   // next-state logic: IDLE/DONE wait for a start edge, RUN ends after step 47
   always_comb begin
      state_d_nx = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d_nx = S_RUN;
         S_RUN:   if (step_q == STEPS_DONE) state_d_nx = S_DONE;
         S_DONE:  if (start) state_d_nx = S_RUN;
         default: state_d_nx = S_IDLE;
      endcase
   end

   // UNROLL chained MD4 steps; the tuple is rotated after every step so the
   // update always lands in slot a and the standard a,d,c,b order falls out
   always_comb begin
      wa = a_q;
      wb = b_q;
      wc = c_q;
      wd = d_q;
      f  = '0;
      kc = '0;
      t  = '0;
      s  = '0;
      j  = '0;
      k  = '0;
      sh = '0;
      for (int unsigned i = 0; i < UNROLL; i++) begin
         s = step_q + 6'(i);
         j = s[3:0];
         case (s[5:4])
            2'd0: begin
               f  = (wb & wc) | (~wb & wd);
               kc = 32'h0000_0000;
               k  = j;
               case (j[1:0])
                  2'd0: sh = 5'd3;
                  2'd1: sh = 5'd7;
                  2'd2: sh = 5'd11;
                  default: sh = 5'd19;
               endcase
            end
            2'd1: begin
               f  = (wb & wc) | (wb & wd) | (wc & wd);
               kc = 32'h5A82_7999;
               k  = {j[1:0], j[3:2]};
               case (j[1:0])
                  2'd0: sh = 5'd3;
                  2'd1: sh = 5'd5;
                  2'd2: sh = 5'd9;
                  default: sh = 5'd13;
               endcase
            end
            default: begin
               f  = wb ^ wc ^ wd;
               kc = 32'h6ED9_EBA1;
               k  = {j[0], j[1], j[2], j[3]};
               case (j[1:0])
                  2'd0: sh = 5'd3;
                  2'd1: sh = 5'd9;
                  2'd2: sh = 5'd11;
                  default: sh = 5'd15;
               endcase
            end
         endcase
         t  = rotl(wa + f + x_q[k] + kc, sh);
         wa = wd;
         wd = wc;
         wc = wb;
         wb = t;
      end
      a_nx = wa;
      b_nx = wb;
      c_nx = wc;
      d_nx = wd;
   end

   // state register, input latch on accept, step advance and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         irdy_q     <= 1'b0;
         step_q     <= '0;
         ordy       <= 1'b0;
         newstate_a <= '0;
         newstate_b <= '0;
         newstate_c <= '0;
         newstate_d <= '0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         d_q        <= '0;
         ia_q       <= '0;
         ib_q       <= '0;
         ic_q       <= '0;
         id_q       <= '0;
         for (int unsigned i = 0; i < 16; i++) x_q[i] <= '0;
      end else begin
         irdy_q  <= irdy;
         state_q <= state_d_nx;
         if (load) begin
            ia_q   <= state_a;
            ib_q   <= state_b;
            ic_q   <= state_c;
            id_q   <= state_d;
            a_q    <= state_a;
            b_q    <= state_b;
            c_q    <= state_c;
            d_q    <= state_d;
            step_q <= '0;
            ordy   <= 1'b0;
            for (int unsigned i = 0; i < 16; i++)
               x_q[i] <= bswap32(data[511 - 32*i -: 32]);
         end else if (finish) begin
            newstate_a <= ia_q + a_q;
            newstate_b <= ib_q + b_q;
            newstate_c <= ic_q + c_q;
            newstate_d <= id_q + d_q;
            ordy       <= 1'b1;
         end else if (state_q == S_RUN) begin
            a_q    <= a_nx;
            b_q    <= b_nx;
            c_q    <= c_nx;
            d_q    <= d_nx;
            step_q <= step_q + 6'(UNROLL);
         end
      end
   end

endmodule

// File: tb/tb_md4_compress.sv
// tb_md4_compress: directed MD4 vectors against UNROLL=1/2/4 instances
// driven in lockstep from a shared stimulus.
module tb_md4_compress;

   logic         clk = 1'b0;
   logic         rst;
   logic         irdy;
   logic [31:0]  st_a, st_b, st_c, st_d;
   logic [511:0] data;
   logic         ordy1, ordy2, ordy4;
   logic [31:0]  n1a, n1b, n1c, n1d;
   logic [31:0]  n2a, n2b, n2c, n2d;
   logic [31:0]  n4a, n4b, n4c, n4d;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
   localparam logic [511:0] BLK_TEST  = {32'h74657374, 8'h80, 408'h0, 8'h20, 56'h0};
   localparam logic [511:0] BLK_REIN  = {128'h7265696E_64656572_666C6F74_696C6C61,
                                         8'h80, 312'h0, 8'h80, 56'h0};
   localparam logic [511:0] BLK_SWORD = {72'h73_776F_7264_6669_7368,
                                         8'h80, 368'h0, 8'h48, 56'h0};

   localparam logic [127:0] H_EMPTY = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
   localparam logic [127:0] H_TEST  = 128'hDB346D691D7ACC4DC2625DB19F9E3F52;
   localparam logic [127:0] H_REIN  = 128'hDEABAE991701C6BEECB3949552F07601;
   localparam logic [127:0] H_SWORD = 128'h5E2047B913668435800AB70F839F62AB;

   always #5 clk = ~clk;

   md4_compress #(.UNROLL(1)) u1 (
      .clk(clk), .rst(rst), .irdy(irdy),
      .state_a(st_a), .state_b(st_b), .state_c(st_c), .state_d(st_d), .data(data),
      .ordy(ordy1), .newstate_a(n1a), .newstate_b(n1b), .newstate_c(n1c), .newstate_d(n1d)
   );
   md4_compress #(.UNROLL(2)) u2 (
      .clk(clk), .rst(rst), .irdy(irdy),
      .state_a(st_a), .state_b(st_b), .state_c(st_c), .state_d(st_d), .data(data),
      .ordy(ordy2), .newstate_a(n2a), .newstate_b(n2b), .newstate_c(n2c), .newstate_d(n2d)
   );
   md4_compress #(.UNROLL(4)) u4 (
      .clk(clk), .rst(rst), .irdy(irdy),
      .state_a(st_a), .state_b(st_b), .state_c(st_c), .state_d(st_d), .data(data),
      .ordy(ordy4), .newstate_a(n4a), .newstate_b(n4b), .newstate_c(n4c), .newstate_d(n4d)
   );

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [127:0] digest(input logic [31:0] a, b, c, d);
      return {bswap32(a), bswap32(b), bswap32(c), bswap32(d)};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ordy"}, {125'h0, ordy4, ordy2, ordy1}, 128'h0);
      chk({tag, "_ns1"}, {n1a, n1b, n1c, n1d}, 128'h0);
      chk({tag, "_ns2"}, {n2a, n2b, n2c, n2d}, 128'h0);
      chk({tag, "_ns4"}, {n4a, n4b, n4c, n4d}, 128'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Raise irdy for `hold` cycles, then watch 55 edges: record each instance's
   // ordy rise edge, confirm ordy never falls again, compare the final digest.
   task automatic run_job(input string tag, input logic [511:0] blk,
                          input logic [127:0] exp, input int hold);
      int lat1, lat2, lat4;
      bit drop1, drop2, drop4;
      lat1 = 0; lat2 = 0; lat4 = 0;
      drop1 = 0; drop2 = 0; drop4 = 0;
      @(negedge clk);
      st_a = 32'h67452301;
      st_b = 32'hEFCDAB89;
      st_c = 32'h98BADCFE;
      st_d = 32'h10325476;
      data = blk;
      irdy = 1'b1;
      @(posedge clk);
      #1;
      if (hold <= 1) irdy = 1'b0;
      // inputs only matter on the accept edge
      data = ~blk;
      st_a = 32'hDEADBEEF;
      chk({tag, "_ordy_accept"}, {125'h0, ordy4, ordy2, ordy1}, 128'h0);
      for (int e = 1; e <= 55; e++) begin
         @(posedge clk);
         #1;
         if (e + 1 >= hold) irdy = 1'b0;
         if (ordy1 && lat1 == 0) lat1 = e;
         if (ordy2 && lat2 == 0) lat2 = e;
         if (ordy4 && lat4 == 0) lat4 = e;
         if (!ordy1 && lat1 != 0) drop1 = 1;
         if (!ordy2 && lat2 != 0) drop2 = 1;
         if (!ordy4 && lat4 != 0) drop4 = 1;
      end
      chk({tag, "_lat1"}, 128'(lat1), 128'd49);
      chk({tag, "_lat2"}, 128'(lat2), 128'd25);
      chk({tag, "_lat4"}, 128'(lat4), 128'd13);
      chk({tag, "_ordy_held"}, {125'h0, drop4, drop2, drop1}, 128'h0);
      chk({tag, "_hash1"}, digest(n1a, n1b, n1c, n1d), exp);
      chk({tag, "_hash2"}, digest(n2a, n2b, n2c, n2d), exp);
      chk({tag, "_hash4"}, digest(n4a, n4b, n4c, n4d), exp);
   endtask

   initial begin
      rst  = 1'b1;
      irdy = 1'b0;
      st_a = '0; st_b = '0; st_c = '0; st_d = '0;
      data = '0;
      repeat (2) @(posedge clk);
      do_reset();

      // 1) idle after reset
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         chk_idle("idle");
      end

      // 2) empty message
      run_job("empty", BLK_EMPTY, H_EMPTY, 1);

      // 3) "test" with irdy held five cycles: one job only
      run_job("test_hold", BLK_TEST, H_TEST, 5);

      // 4) back-to-back jobs started from DONE
      run_job("rein", BLK_REIN, H_REIN, 1);
      run_job("sword", BLK_SWORD, H_SWORD, 1);

      // 5) reset mid-job, then rerun
      @(negedge clk);
      st_a = 32'h67452301; st_b = 32'hEFCDAB89; st_c = 32'h98BADCFE; st_d = 32'h10325476;
      data = BLK_TEST;
      irdy = 1'b1;
      @(posedge clk);
      #1;
      irdy = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_idle("after_rst");
      repeat (3) @(posedge clk);
      #1;
      chk_idle("after_rst_hold");
      run_job("test_rerun", BLK_TEST, H_TEST, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
